round_seq_ctrl: RTL and testbench
=================================

Name: round_seq_ctrl

Overview:
Sequencer for the 32-lane 16b-to-8b rounding array (32 lanes, 512-bit in, 256-bit out, fixed pipeline latency).
- Accepts one per-layer configuration and a beat count, then streams bias beats into the array.
- Tracks beats in flight through the array and buffers array results in an output FIFO.
- Throttles issue by credits, so the non-stallable array never overruns a stalled consumer.
- Sits between the accumulator/bias stage and the output writeback stage of the NPU core.

Parameters:
ARR_LAT, 2, array latency in cycles from input beat to valid output beat (1..4)
FIFO_DEPTH, 4, output FIFO entries, power of 2, must be >= ARR_LAT+1
CNT_W, 16, beat counter width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_cfg_vld  in  1  configuration request
o_cfg_rdy  out  1  high only in IDLE
i_cfg_iq  in  4  input Q encode
i_cfg_wq  in  4  weight Q encode
i_cfg_oq  in  4  output Q encode
i_cfg_mode  in  2  round mode (0 trunc, 1 nearest)
i_cfg_shift_en  in  1  shift enable
i_cfg_bypass  in  32  per-lane bypass mask
i_cfg_beats  in  CNT_W  beats in this layer, 0 is legal
i_dat_vld  in  1  bias beat valid
o_dat_rdy  out  1  bias beat accept
i_dat  in  512  bias beat (32 x 16b)
o_arr_dat  out  512  to array input
o_arr_shift_num  out  5  to array
o_arr_shift_en  out  1  to array
o_arr_mode  out  2  to array
o_arr_bypass  out  32  to array
i_arr_dat  in  256  array output
o_out_vld  out  1  rounded beat valid
i_out_rdy  in  1  consumer ready
o_out_dat  out  256  rounded beat
o_busy  out  1  not IDLE
o_done  out  1  one-cycle pulse when layer completes
o_cfg_err  out  1  sticky configuration error, cleared on next cfg accept

Behaviour:
Reset values:
- All outputs 0, FIFO empty, counters 0, state IDLE.
- o_cfg_rdy is combinational from state, so it rises 1 cycle after reset release.

States and transitions:
- IDLE: o_cfg_rdy=1. On i_cfg_vld, latch all cfg fields.
  - Compute shift = iq+wq-oq as 6-bit signed.
  - If beats==0, go to DONE; otherwise go to RUN.
- RUN: issue = i_dat_vld && o_dat_rdy.
  - o_dat_rdy = (inflight + fifo_cnt < FIFO_DEPTH), where inflight = valid bits in an ARR_LAT-deep shift register.
  - On issue: drive o_arr_dat=i_dat that cycle, push 1 into the valid shift register, decrement the remaining-beat counter.
  - When the last beat issues, go to DRAIN.
- DRAIN: o_dat_rdy=0. When inflight==0 and the FIFO is empty, go to DONE.
- DONE: o_done=1 for one cycle, then go to IDLE.

Array and FIFO timing:
- o_arr_shift_num/en/mode/bypass are registered from the latched cfg and are stable for the whole layer.
- They update only on cfg accept, so they are valid at least 1 cycle before the first issue.
- When the valid shift register output is 1, i_arr_dat is written into the FIFO in that same cycle. Latency from issue to FIFO write is exactly ARR_LAT cycles.
- FIFO output is first-word-fall-through. o_out_vld = !empty; pop on o_out_vld && i_out_rdy.
- A simultaneous push and pop keeps the count unchanged. Overflow is impossible by the credit rule, and the bench asserts it never occurs.

Boundary conditions:
- Full credits: rdy drops the same cycle.
- Pop and issue in the same cycle: the credit frees next cycle (registered count, no combinational path from i_out_rdy to o_dat_rdy).
- o_arr_dat is don't-care when not issuing; hold the last value.
- Reset mid-layer: everything clears immediately, in-flight data is discarded, no o_done.
- i_cfg_vld outside IDLE is ignored.

Optional Feature:
Macro ROUND_SEQ_SHIFT_CHK_EN.
- Defined: if shift<0 or shift>15, set o_cfg_err, clamp shift_num to 0 (negative) or 15 (large), and still run the layer.
- Undefined: shift_num = low 5 bits of iq+wq-oq (mod-32 wrap); o_cfg_err is tied 0.

Decomposition:
- Shared package npu_round_pkg: state encoding (IDLE/RUN/DRAIN/DONE), LANES=32, IN_W=16, OUT_W=8, round-mode constants.
- One sub-module: round_out_fifo (parameterised FWFT FIFO, DEPTH/WIDTH, count output).

Test Plan:
1. Cfg iq=6, wq=5, oq=4, beats=8; out_rdy=1 -> shift_num=7; 8 outputs in order; first o_out_vld ARR_LAT+1 cycles after first issue; o_done 1 pulse; o_busy falls after it.
2. beats=0 -> IDLE, DONE, IDLE in 2 cycles; no o_dat_rdy; one o_done pulse.
3. beats=20, i_out_rdy=0 -> exactly FIFO_DEPTH beats issued, then o_dat_rdy=0. Release rdy -> all 20 beats delivered, no loss or duplication.
4. Random i_dat_vld/i_out_rdy at 50% over 200 beats -> output sequence matches the scoreboard; FIFO never overflows.
5. iq=2, wq=1, oq=7 with macro defined -> o_cfg_err=1, shift_num=0. Without the macro -> shift_num=28, o_cfg_err=0.
6. Assert i_rst_n=0 at beat 5 of 10 -> all outputs 0 next edge. New cfg after reset runs cleanly with no stale outputs.

Source files
------------

// File: rtl/npu_round_pkg.sv
// Shared definitions for the rounding-array sequencer slice:
// FSM state encoding, array geometry, round-mode codes and shift helper.
package npu_round_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int LANES = 32;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;

  localparam logic [1:0] RND_TRUNC   = 2'd0;
  localparam logic [1:0] RND_NEAREST = 2'd1;

  // Raw rounding shift iq + wq - oq as a 6-bit two's complement value.
  function automatic logic [5:0] calc_shift(input logic [3:0] iq,
                                            input logic [3:0] wq,
                                            input logic [3:0] oq);
    return {2'b00, iq} + {2'b00, wq} - {2'b00, oq};
  endfunction

endpackage

// File: rtl/round_out_fifo.sv
// First-word-fall-through FIFO buffering rounded beats from the array.
// Head data reads as zero while empty so no stale entry is ever visible.
module round_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;

  assign pop_ok  = i_pop && !o_empty;
  assign o_empty = (o_cnt == '0);
  assign o_dout  = o_empty ? '0 : mem[rd_ptr];

  // Storage array, written at the tail on every push.
  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr] <= i_din;
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_cnt  <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({i_push, pop_ok})
        2'b10:   o_cnt <= o_cnt + 1'b1;
        2'b01:   o_cnt <= o_cnt - 1'b1;
        default: o_cnt <= o_cnt;
      endcase
    end
  end

endmodule

// File: rtl/round_seq_ctrl.sv
// Sequencer for the 32-lane 16b-to-8b rounding array.
// Latches a layer configuration, streams bias beats into the fixed-latency
// array under a credit limit, and buffers array results in an output FIFO.
// Optional macro ROUND_SEQ_SHIFT_CHK_EN: range-check and clamp the shift,
// flagging out-of-range configurations on o_cfg_err.
module round_seq_ctrl
  import npu_round_pkg::*;
#(
  parameter int ARR_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cfg_vld,
  output logic                   o_cfg_rdy,
  input  logic [3:0]             i_cfg_iq,
  input  logic [3:0]             i_cfg_wq,
  input  logic [3:0]             i_cfg_oq,
  input  logic [1:0]             i_cfg_mode,
  input  logic                   i_cfg_shift_en,
  input  logic [LANES-1:0]       i_cfg_bypass,
  input  logic [CNT_W-1:0]       i_cfg_beats,
  input  logic                   i_dat_vld,
  output logic                   o_dat_rdy,
  input  logic [LANES*IN_W-1:0]  i_dat,
  output logic [LANES*IN_W-1:0]  o_arr_dat,
  output logic [4:0]             o_arr_shift_num,
  output logic                   o_arr_shift_en,
  output logic [1:0]             o_arr_mode,
  output logic [LANES-1:0]       o_arr_bypass,
  input  logic [LANES*OUT_W-1:0] i_arr_dat,
  output logic                   o_out_vld,
  input  logic                   i_out_rdy,
  output logic [LANES*OUT_W-1:0] o_out_dat,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_cfg_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  state_t                  state, state_nxt;
  logic                    rdy_en;
  logic                    cfg_acc;
  logic                    issue;
  logic                    credit_ok;
  logic [CNT_W-1:0]        rem;
  logic [ARR_LAT-1:0]      vld_sr;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           fifo_cnt;
  logic [CW:0]             credit_sum;
  logic                    fifo_empty;
  logic [LANES*IN_W-1:0]   arr_dat_q;
  logic [5:0]              shift_raw;
  logic [4:0]              shift_num_c;

  // rdy_en keeps o_cfg_rdy low during reset and for the release cycle.
  assign o_cfg_rdy = rdy_en && (state == ST_IDLE);
  assign cfg_acc   = o_cfg_rdy && i_cfg_vld;
  assign o_busy    = (state != ST_IDLE);
  assign o_done    = (state == ST_DONE);

  // Credits use only registered occupancy, so i_out_rdy never reaches o_dat_rdy.
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign credit_ok  = (credit_sum < DEPTH_C);
  assign o_dat_rdy  = (state == ST_RUN) && credit_ok;
  assign issue      = i_dat_vld && o_dat_rdy;
  assign o_arr_dat  = issue ? i_dat : arr_dat_q;
  assign o_out_vld  = !fifo_empty;

  // Beats currently travelling through the array.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ARR_LAT; i++) inflight += CW'(vld_sr[i]);
  end

  // Shift decode from the incoming configuration.
  always_comb begin
    shift_raw = calc_shift(i_cfg_iq, i_cfg_wq, i_cfg_oq);
`ifdef ROUND_SEQ_SHIFT_CHK_EN
    if (shift_raw[5])            shift_num_c = 5'd0;
    else if (shift_raw > 6'd15)  shift_num_c = 5'd15;
    else                         shift_num_c = shift_raw[4:0];
`else
    shift_num_c = shift_raw[4:0];
`endif
  end

`ifdef ROUND_SEQ_SHIFT_CHK_EN
  // Sticky range error, reloaded on each configuration accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     o_cfg_err <= 1'b0;
    else if (cfg_acc) o_cfg_err <= shift_raw[5] || (shift_raw > 6'd15);
  end
`else
  assign o_cfg_err = 1'b0;
`endif

  // State register plus reset-release gate for o_cfg_rdy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
    end
  end

  // Next-state logic for the layer sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cfg_acc) state_nxt = (i_cfg_beats == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (issue && (rem == CNT_W'(1))) state_nxt = ST_DRAIN;
      ST_DRAIN: if ((inflight == '0) && fifo_empty) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Array controls held stable for the whole layer, loaded on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_arr_shift_num <= '0;
      o_arr_shift_en  <= 1'b0;
      o_arr_mode      <= '0;
      o_arr_bypass    <= '0;
    end else if (cfg_acc) begin
      o_arr_shift_num <= shift_num_c;
      o_arr_shift_en  <= i_cfg_shift_en;
      o_arr_mode      <= i_cfg_mode;
      o_arr_bypass    <= i_cfg_bypass;
    end
  end

  // Remaining beats, in-flight valid pipeline and last issued beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem       <= '0;
      vld_sr    <= '0;
      arr_dat_q <= '0;
    end else begin
      if (cfg_acc)    rem <= i_cfg_beats;
      else if (issue) rem <= rem - 1'b1;
      vld_sr[0] <= issue;
      for (int unsigned i = 1; i < ARR_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      if (issue) arr_dat_q <= i_dat;
    end
  end

  round_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LANES*OUT_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (vld_sr[ARR_LAT-1]),
    .i_din   (i_arr_dat),
    .i_pop   (i_out_rdy),
    .o_dout  (o_out_dat),
    .o_empty (fifo_empty),
    .o_cnt   (fifo_cnt)
  );

endmodule

// File: tb/tb_round_seq_ctrl.sv
// Scoreboard bench for round_seq_ctrl with a behavioural array model
// (each lane's result is the low byte of its 16-bit input).
module tb_round_seq_ctrl;

  localparam int ARR_LAT    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             cfg_vld, cfg_rdy;
  logic [3:0]       cfg_iq, cfg_wq, cfg_oq;
  logic [1:0]       cfg_mode;
  logic             cfg_shift_en;
  logic [31:0]      cfg_bypass;
  logic [CNT_W-1:0] cfg_beats;
  logic             dat_vld, dat_rdy;
  logic [511:0]     cur_dat, arr_dat;
  logic [4:0]       shift_num;
  logic             shift_en;
  logic [1:0]       arr_mode;
  logic [31:0]      arr_bypass;
  logic [255:0]     arr_res;
  logic             out_vld, out_rdy;
  logic [255:0]     out_dat;
  logic             busy, done, cfg_err;

  round_seq_ctrl #(
    .ARR_LAT    (ARR_LAT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_cfg_vld       (cfg_vld),
    .o_cfg_rdy       (cfg_rdy),
    .i_cfg_iq        (cfg_iq),
    .i_cfg_wq        (cfg_wq),
    .i_cfg_oq        (cfg_oq),
    .i_cfg_mode      (cfg_mode),
    .i_cfg_shift_en  (cfg_shift_en),
    .i_cfg_bypass    (cfg_bypass),
    .i_cfg_beats     (cfg_beats),
    .i_dat_vld       (dat_vld),
    .o_dat_rdy       (dat_rdy),
    .i_dat           (cur_dat),
    .o_arr_dat       (arr_dat),
    .o_arr_shift_num (shift_num),
    .o_arr_shift_en  (shift_en),
    .o_arr_mode      (arr_mode),
    .o_arr_bypass    (arr_bypass),
    .i_arr_dat       (arr_res),
    .o_out_vld       (out_vld),
    .i_out_rdy       (out_rdy),
    .o_out_dat       (out_dat),
    .o_busy          (busy),
    .o_done          (done),
    .o_cfg_err       (cfg_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] low_bytes(input logic [511:0] d);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[k*8 +: 8] = d[k*16 +: 8];
    return r;
  endfunction

  function automatic logic [511:0] mk_beat(input int id);
    logic [511:0] b;
    for (int k = 0; k < 32; k++) b[k*16 +: 16] = {8'(k), 8'(id + k)};
    return b;
  endfunction

  // Array model: fixed ARR_LAT-cycle pipeline on the array input bus.
  logic [511:0] pipe [ARR_LAT];
  always @(posedge clk) begin
    pipe[0] <= arr_dat;
    for (int i = 1; i < ARR_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign arr_res = low_bytes(pipe[ARR_LAT-1]);

  // Scoreboard and monitor state.
  logic [255:0] sb [$];
  int issued = 0, popped = 0, n_done = 0, cyc = 0;
  int first_iss = -1, first_vld = -1;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dat_vld && dat_rdy) begin
        chk("arr_dat_on_issue", arr_dat, cur_dat);
        sb.push_back(low_bytes(cur_dat));
        issued++;
        if (first_iss < 0) first_iss = cyc;
        checks++;
        if (issued - popped > FIFO_DEPTH) begin
          failures++;
          $display("FAIL overflow outstanding=%0d limit=%0d", issued - popped, FIFO_DEPTH);
        end
      end
      if (out_vld && first_vld < 0) first_vld = cyc;
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", out_dat);
        end else begin
          chk("out_dat", out_dat, sb.pop_front());
        end
        popped++;
      end
      if (done) n_done++;
    end
  end

  int next_id = 0;

  task automatic do_cfg(input logic [3:0] iq, input logic [3:0] wq, input logic [3:0] oq,
                        input logic [1:0] mode, input logic sh_en, input logic [31:0] byp,
                        input int beats);
    int n = 0;
    while (!cfg_rdy && n < 20) begin @(posedge clk); #1; n++; end
    chk("cfg_rdy_wait", cfg_rdy, 1);
    cfg_iq = iq; cfg_wq = wq; cfg_oq = oq; cfg_mode = mode;
    cfg_shift_en = sh_en; cfg_bypass = byp; cfg_beats = CNT_W'(beats);
    cfg_vld = 1'b1;
    @(posedge clk); #1;
    cfg_vld = 1'b0;
  endtask

  task automatic send_beats(input int n, input int vld_pct, input int rdy_pct, input int budget);
    int sent = 0, c = 0;
    while (sent < n && c < budget) begin
      dat_vld = ($urandom_range(99) < vld_pct);
      out_rdy = ($urandom_range(99) < rdy_pct);
      cur_dat = mk_beat(next_id);
      @(negedge clk);
      if (dat_vld && dat_rdy) begin sent++; next_id++; end
      @(posedge clk); #1;
      c++;
    end
    dat_vld = 1'b0;
    chk("beats_sent", sent, n);
  endtask

  task automatic wait_done(input int rdy_pct, input int budget);
    int c = 0;
    while (!done && c < budget) begin
      out_rdy = ($urandom_range(99) < rdy_pct);
      @(posedge clk); #1;
      c++;
    end
    chk("done_seen", done, 1);
    chk("busy_with_done", busy, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int d0, sent;
    rst_n = 1'b0; cfg_vld = 1'b0; cfg_iq = '0; cfg_wq = '0; cfg_oq = '0;
    cfg_mode = '0; cfg_shift_en = 1'b0; cfg_bypass = '0; cfg_beats = '0;
    dat_vld = 1'b0; cur_dat = '0; out_rdy = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg_rdy", cfg_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_shift_num", shift_num, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_cfg_rdy_low", cfg_rdy, 0);
    @(posedge clk); #1;
    chk("rel_cfg_rdy_high", cfg_rdy, 1);

    // Test 1: basic layer, 8 beats, consumer always ready
    d0 = n_done; first_iss = -1; first_vld = -1;
    do_cfg(4'd6, 4'd5, 4'd4, 2'd1, 1'b1, 32'hDEAD_BEEF, 8);
    chk("t1_shift_num", shift_num, 7);
    chk("t1_shift_en", shift_en, 1);
    chk("t1_mode", arr_mode, 1);
    chk("t1_bypass", arr_bypass, 32'hDEAD_BEEF);
    chk("t1_cfg_err", cfg_err, 0);
    chk("t1_cfg_ignored_busy", cfg_rdy, 0);
    send_beats(8, 100, 100, 100);
    wait_done(100, 100);
    chk("t1_latency", first_vld - first_iss, ARR_LAT + 1);
    chk("t1_done_count", n_done - d0, 1);
    chk("t1_all_out", popped, issued);

    // Test 2: zero-beat layer
    d0 = n_done;
    do_cfg(4'd1, 4'd1, 4'd1, 2'd0, 1'b0, 32'h0, 0);
    chk("t2_done", done, 1);
    chk("t2_dat_rdy", dat_rdy, 0);
    @(posedge clk); #1;
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_cfg_rdy", cfg_rdy, 1);
    chk("t2_done_count", n_done - d0, 1);

    // Test 3: stalled consumer fills exactly the credit window
    do_cfg(4'd6, 4'd5, 4'd4, 2'd0, 1'b1, 32'h0, 20);
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      dat_vld = 1'b1; out_rdy = 1'b0; cur_dat = mk_beat(next_id);
      @(negedge clk);
      if (dat_vld && dat_rdy) begin sent++; next_id++; end
      @(posedge clk); #1;
    end
    chk("t3_issued_stalled", sent, FIFO_DEPTH);
    chk("t3_dat_rdy_low", dat_rdy, 0);
    chk("t3_out_vld", out_vld, 1);
    send_beats(20 - FIFO_DEPTH, 100, 100, 200);
    wait_done(100, 100);
    chk("t3_all_out", popped, issued);

    // Test 4: random valid/ready over 200 beats
    do_cfg(4'd3, 4'd3, 4'd2, 2'd1, 1'b1, 32'h0000_FFFF, 200);
    send_beats(200, 50, 50, 5000);
    wait_done(50, 500);
    chk("t4_all_out", popped, issued);

    // Test 5: out-of-range shift (negative)
    do_cfg(4'd2, 4'd1, 4'd7, 2'd0, 1'b1, 32'h0, 1);
`ifdef ROUND_SEQ_SHIFT_CHK_EN
    chk("t5_shift_num", shift_num, 0);
    chk("t5_cfg_err", cfg_err, 1);
`else
    chk("t5_shift_num", shift_num, 28);
    chk("t5_cfg_err", cfg_err, 0);
`endif
    send_beats(1, 100, 100, 50);
    wait_done(100, 50);

    // Test 6: reset in the middle of a 10-beat layer
    do_cfg(4'd6, 4'd5, 4'd4, 2'd1, 1'b1, 32'hFFFF_0000, 10);
    send_beats(5, 100, 100, 50);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_out_vld", out_vld, 0);
    chk("t6_out_dat", out_dat, 0);
    chk("t6_dat_rdy", dat_rdy, 0);
    chk("t6_cfg_rdy", cfg_rdy, 0);
    chk("t6_done", done, 0);
    chk("t6_shift_num", shift_num, 0);
    chk("t6_bypass", arr_bypass, 0);
    chk("t6_arr_dat", arr_dat, 0);
    sb.delete(); issued = 0; popped = 0;
    d0 = n_done;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_no_done", n_done - d0, 0);
    chk("t6_out_vld_after", out_vld, 0);
    do_cfg(4'd4, 4'd4, 4'd4, 2'd0, 1'b0, 32'h1234_5678, 4);
    chk("t6_new_shift", shift_num, 4);
    chk("t6_new_bypass", arr_bypass, 32'h1234_5678);
    send_beats(4, 100, 100, 50);
    wait_done(100, 50);
    chk("t6_new_count", popped, 4);
    chk("t6_new_done", n_done - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
